// File: rtl/iic_slave_if.sv
// iic_slave bus bundle: SCL and the two halves of SDA.
// The master drives scl/sda_in; the target drives sda_out.
interface iic_slave_if;
  logic scl;
  logic sda_in;
  logic sda_out;

  modport master (
    output scl,
    output sda_in,
    input  sda_out
  );

  modport slave (
    input  scl,
    input  sda_in,
    output sda_out
  );
endinterface

// File: rtl/iic_slave.sv
// iic_slave: I2C target serving a byte memory via a 1/2-byte word address.
// Define IIC_SLAVE_AUTOINC_EN for pointer auto-increment (sequential access).
module iic_slave #(
  parameter logic [6:0] DEVICE_ADDR = 7'b1010000,
  parameter int         ADDR_BYTES  = 2,
  parameter int         MEM_AW      = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  iic_slave_if.slave        bus,
  output logic              wr_en,
  output logic [MEM_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy
);

`ifdef IIC_SLAVE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_DEV, S_ACK_DEV,
    S_ADDR_H, S_ACK_AH,
    S_ADDR_L, S_ACK_AL,
    S_WR, S_ACK_WR,
    S_RD, S_RACK
  } state_t;

  state_t            state, state_nx;
  logic [1:0]        scl_s, sda_s;
  logic              scl_d, sda_d;
  logic              scl_r, scl_f;
  logic              start, stop;
  logic [3:0]        cnt, cnt_nx;
  logic [7:0]        sh, sh_nx;
  logic [7:0]        hi, hi_nx;
  logic [7:0]        byte_in, rd_byte;
  logic [MEM_AW-1:0] ptr, ptr_nx;
  logic              sda_q, sda_nx;
  logic              wr_go, last;

  logic [7:0] mem [0:(1<<MEM_AW)-1];

  assign scl_r   = scl_s[1] & ~scl_d;
  assign scl_f   = ~scl_s[1] & scl_d;
  assign start   = scl_s[1] & scl_d & sda_d & ~sda_s[1];
  assign stop    = scl_s[1] & scl_d & ~sda_d & sda_s[1];
  assign byte_in = {sh[6:0], sda_s[1]};
  assign rd_byte = mem[ptr];
  assign last    = (cnt == 4'd7);
  assign bus.sda_out = sda_q;

  // Synchronise SCL/SDA and keep one delayed copy for edge detection
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      scl_s <= 2'b11;
      sda_s <= 2'b11;
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_s <= {scl_s[0], bus.scl};
      sda_s <= {sda_s[0], bus.sda_in};
      scl_d <= scl_s[1];
      sda_d <= sda_s[1];
    end
  end

  // Next-state, shift, pointer and SDA drive decisions
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sh_nx    = sh;
    hi_nx    = hi;
    ptr_nx   = ptr;
    sda_nx   = sda_q;
    wr_go    = 1'b0;
    if (start) begin
      state_nx = S_DEV;
      cnt_nx   = '0;
      sda_nx   = 1'b1;
    end else if (stop) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
      sda_nx   = 1'b1;
    end else begin
      unique case (state)
        S_IDLE: ;
        S_DEV, S_ADDR_H, S_ADDR_L, S_WR: begin
          if (scl_r) begin
            sh_nx  = byte_in;
            cnt_nx = cnt + 4'd1;
            if (last) begin
              case (state)
                S_DEV: begin
                  if (byte_in[7:1] == DEVICE_ADDR) begin
                    state_nx = S_ACK_DEV;
                  end else begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                  end
                end
                S_ADDR_H: begin
                  hi_nx    = byte_in;
                  state_nx = S_ACK_AH;
                end
                S_ADDR_L: begin
                  ptr_nx   = MEM_AW'({hi, byte_in});
                  state_nx = S_ACK_AL;
                end
                default: begin
                  wr_go    = 1'b1;
                  state_nx = S_ACK_WR;
                  if (AUTOINC) ptr_nx = ptr + MEM_AW'(1);
                end
              endcase
            end
          end
        end
        S_ACK_DEV, S_ACK_AH, S_ACK_AL, S_ACK_WR: begin
          if (scl_f && cnt == 4'd8) begin
            sda_nx = 1'b0;
          end else if (scl_r && cnt == 4'd8) begin
            cnt_nx = 4'd9;
          end else if (scl_f && cnt == 4'd9) begin
            sda_nx = 1'b1;
            cnt_nx = '0;
            case (state)
              S_ACK_DEV: begin
                if (sh[0]) begin
                  state_nx = S_RD;
                  sh_nx    = rd_byte;
                  sda_nx   = rd_byte[7];
                  cnt_nx   = 4'd1;
                end else if (ADDR_BYTES == 2) begin
                  state_nx = S_ADDR_H;
                end else begin
                  state_nx = S_ADDR_L;
                end
              end
              S_ACK_AH: state_nx = S_ADDR_L;
              default:  state_nx = S_WR;
            endcase
          end
        end
        S_RD: begin
          if (scl_f) begin
            if (cnt == 4'd8) begin
              sda_nx   = 1'b1;
              cnt_nx   = '0;
              state_nx = S_RACK;
            end else begin
              sda_nx = sh[6];
              sh_nx  = {sh[6:0], 1'b0};
              cnt_nx = cnt + 4'd1;
            end
          end
        end
        S_RACK: begin
          if (scl_r && cnt == 4'd0) begin
            if (!sda_s[1]) begin
              cnt_nx = 4'd1;
              if (AUTOINC) ptr_nx = ptr + MEM_AW'(1);
            end else begin
              state_nx = S_IDLE;
            end
          end else if (scl_f && cnt == 4'd1) begin
            state_nx = S_RD;
            sh_nx    = rd_byte;
            sda_nx   = rd_byte[7];
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // State, datapath and output registers
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      sh      <= '0;
      hi      <= '0;
      ptr     <= '0;
      sda_q   <= 1'b1;
      busy    <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      sh    <= sh_nx;
      hi    <= hi_nx;
      ptr   <= ptr_nx;
      sda_q <= sda_nx;
      busy  <= (state_nx != S_IDLE);
      wr_en <= wr_go;
      if (wr_go) begin
        wr_addr <= ptr;
        wr_data <= byte_in;
      end
    end
  end

  // Byte memory write port; contents survive reset
  always_ff @(posedge sys_clk) begin
    if (wr_go) mem[ptr] <= byte_in;
  end

endmodule

// File: tb/tb_iic_slave.sv
// tb_iic_slave: bit-banged I2C master driving iic_slave.
// Table of write/read transactions plus abort and reset sequences.
module tb_iic_slave;

  localparam int Q = 100;

`ifdef IIC_SLAVE_AUTOINC_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  typedef struct {
    logic        rd;
    logic [7:0]  dev;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        exp_ack;
    logic [7:0]  exp_wa;
    logic [7:0]  exp_rd;
  } vec_t;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b0;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  int         n_vec = 0;
  int         n_bad = 0;
  int         wr_cnt = 0;
  logic [7:0] last_addr = '0;
  logic [7:0] last_data = '0;

  iic_slave_if bus ();

  iic_slave #(
    .DEVICE_ADDR (7'b1010000),
    .ADDR_BYTES  (2),
    .MEM_AW      (8)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (wr_en) begin
      wr_cnt    = wr_cnt + 1;
      last_addr = wr_addr;
      last_data = wr_data;
    end
  end

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic i2c_start();
    bus.sda_in = 1'b1; #Q;
    bus.scl    = 1'b1; #Q;
    bus.sda_in = 1'b0; #Q;
    bus.scl    = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    bus.sda_in = 1'b0; #Q;
    bus.scl    = 1'b1; #Q;
    bus.sda_in = 1'b1; #Q;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      bus.sda_in = b[i]; #Q;
      bus.scl    = 1'b1; #Q;
      bus.scl    = 1'b0; #Q;
    end
  endtask

  task automatic ack_slot(output logic a);
    bus.sda_in = 1'b1; #Q;
    bus.scl    = 1'b1; #(Q/2);
    a = bus.sda_out;   #(Q/2);
    bus.scl    = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic a);
    send_bits(b, 8);
    ack_slot(a);
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic mack);
    for (int i = 7; i >= 0; i--) begin
      bus.sda_in = 1'b1; #Q;
      bus.scl    = 1'b1; #(Q/2);
      b[i] = bus.sda_out; #(Q/2);
      bus.scl    = 1'b0; #Q;
    end
    bus.sda_in = mack; #Q;
    bus.scl    = 1'b1; #Q;
    bus.scl    = 1'b0; #Q;
  endtask

  task automatic rd_setup(input logic [15:0] addr);
    logic a;
    i2c_start();
    send_byte(8'hA0, a);      chk("rd_dev_w_ack", 16'(a), 16'h0);
    send_byte(addr[15:8], a); chk("rd_ah_ack", 16'(a), 16'h0);
    send_byte(addr[7:0], a);  chk("rd_al_ack", 16'(a), 16'h0);
    i2c_start();
    send_byte(8'hA1, a);      chk("rd_dev_r_ack", 16'(a), 16'h0);
  endtask

  task automatic do_write(input logic [15:0] addr,
                          input logic [7:0] d);
    logic a;
    i2c_start();
    send_byte(8'hA0, a);      chk("w_dev_ack", 16'(a), 16'h0);
    send_byte(addr[15:8], a); chk("w_ah_ack", 16'(a), 16'h0);
    send_byte(addr[7:0], a);  chk("w_al_ack", 16'(a), 16'h0);
    send_byte(d, a);          chk("w_data_ack", 16'(a), 16'h0);
    i2c_stop();
  endtask

  vec_t       vt [8];
  vec_t       v;
  logic       a;
  logic [7:0] b0, b1;
  int         wc;

  initial begin
    vt[0] = '{1'b0, 8'hA0, 16'h0079, 8'hD1, 1'b0, 8'h79, 8'h00};
    vt[1] = '{1'b1, 8'hA1, 16'h0079, 8'h00, 1'b0, 8'h00, 8'hD1};
    vt[2] = '{1'b0, 8'hA0, 16'h0010, 8'h5A, 1'b0, 8'h10, 8'h00};
    vt[3] = '{1'b1, 8'hA1, 16'h0010, 8'h00, 1'b0, 8'h00, 8'h5A};
    vt[4] = '{1'b0, 8'hA2, 16'h0079, 8'hEE, 1'b1, 8'h00, 8'h00};
    vt[5] = '{1'b1, 8'hA1, 16'h0079, 8'h00, 1'b0, 8'h00, 8'hD1};
    vt[6] = '{1'b0, 8'hA0, 16'h01AC, 8'h3E, 1'b0, 8'hAC, 8'h00};
    vt[7] = '{1'b1, 8'hA1, 16'h00AC, 8'h00, 1'b0, 8'h00, 8'h3E};

    bus.scl    = 1'b1;
    bus.sda_in = 1'b1;
    #50;
    chk("rst_sda_out", 16'(bus.sda_out), 16'h1);
    chk("rst_wr_en", 16'(wr_en), 16'h0);
    chk("rst_wr_addr", 16'(wr_addr), 16'h0);
    chk("rst_wr_data", 16'(wr_data), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    sys_rst = 1'b1;
    #Q;

    for (int i = 0; i < 8; i++) begin
      v = vt[i];
      if (v.rd) begin
        rd_setup(v.addr);
        recv_byte(b0, 1'b1);
        chk("rd_nack_busy", 16'(busy), 16'h0);
        chk("rd_nack_sda", 16'(bus.sda_out), 16'h1);
        i2c_stop();
        chk("rd_data", 16'(b0), 16'(v.exp_rd));
      end else begin
        wc = wr_cnt;
        i2c_start();
        send_byte(v.dev, a);
        chk("dev_ack", 16'(a), 16'(v.exp_ack));
        if (!v.exp_ack) begin
          chk("busy_mid", 16'(busy), 16'h1);
          send_byte(v.addr[15:8], a);
          chk("ah_ack", 16'(a), 16'h0);
          send_byte(v.addr[7:0], a);
          chk("al_ack", 16'(a), 16'h0);
          send_byte(v.data, a);
          chk("data_ack", 16'(a), 16'h0);
        end
        i2c_stop();
        chk("wr_count", 16'(wr_cnt - wc), v.exp_ack ? 16'h0 : 16'h1);
        if (!v.exp_ack) begin
          chk("wr_addr", 16'(last_addr), 16'(v.exp_wa));
          chk("wr_data", 16'(last_data), 16'(v.data));
        end
        chk("busy_after", 16'(busy), 16'h0);
      end
    end

    wc = wr_cnt;
    i2c_start();
    send_byte(8'hA0, a); chk("seq_dev_ack", 16'(a), 16'h0);
    send_byte(8'h00, a); chk("seq_ah_ack", 16'(a), 16'h0);
    send_byte(8'hFF, a); chk("seq_al_ack", 16'(a), 16'h0);
    send_byte(8'hC9, a); chk("seq_d0_ack", 16'(a), 16'h0);
    chk("seq_d0_addr", 16'(last_addr), 16'hFF);
    send_byte(8'h85, a); chk("seq_d1_ack", 16'(a), 16'h0);
    i2c_stop();
    chk("seq_wr_count", 16'(wr_cnt - wc), 16'h2);
    chk("seq_d1_addr", 16'(last_addr), AUTO ? 16'h00 : 16'hFF);
    chk("seq_d1_data", 16'(last_data), 16'h85);
    rd_setup(16'h00FF);
    recv_byte(b0, 1'b0);
    recv_byte(b1, 1'b1);
    i2c_stop();
    chk("seq_rd0", 16'(b0), AUTO ? 16'hC9 : 16'h85);
    chk("seq_rd1", 16'(b1), 16'h85);

    wc = wr_cnt;
    i2c_start();
    send_byte(8'hA0, a); chk("abt_dev_ack", 16'(a), 16'h0);
    send_byte(8'h00, a); chk("abt_ah_ack", 16'(a), 16'h0);
    send_byte(8'hAC, a); chk("abt_al_ack", 16'(a), 16'h0);
    send_bits(8'hF0, 4);
    i2c_stop();
    chk("abt_no_wr", 16'(wr_cnt - wc), 16'h0);
    chk("abt_sda", 16'(bus.sda_out), 16'h1);
    chk("abt_busy", 16'(busy), 16'h0);
    do_write(16'h00AC, 8'h9C);
    chk("abt_wr_count", 16'(wr_cnt - wc), 16'h1);
    chk("abt_wr_addr", 16'(last_addr), 16'hAC);
    chk("abt_wr_data", 16'(last_data), 16'h9C);
    rd_setup(16'h00AC);
    recv_byte(b0, 1'b1);
    i2c_stop();
    chk("abt_rd", 16'(b0), 16'h9C);

    i2c_start();
    send_bits(8'hA0, 8);
    bus.sda_in = 1'b1; #Q;
    bus.scl    = 1'b1; #(Q/2);
    chk("rst_pre_ack", 16'(bus.sda_out), 16'h0);
    chk("rst_pre_busy", 16'(busy), 16'h1);
    sys_rst = 1'b0;
    #1;
    chk("rst_mid_sda", 16'(bus.sda_out), 16'h1);
    chk("rst_mid_busy", 16'(busy), 16'h0);
    chk("rst_mid_wr_en", 16'(wr_en), 16'h0);
    #(Q/2 - 1);
    bus.scl = 1'b0; #Q;
    sys_rst = 1'b1; #Q;
    bus.scl = 1'b1; #Q;
    wc = wr_cnt;
    do_write(16'h0042, 8'h33);
    chk("post_rst_wr", 16'(wr_cnt - wc), 16'h1);
    chk("post_rst_addr", 16'(last_addr), 16'h42);
    chk("post_rst_data", 16'(last_data), 16'h33);
    rd_setup(16'h0042);
    recv_byte(b0, 1'b1);
    i2c_stop();
    chk("post_rst_rd", 16'(b0), 16'h33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
